// File: rtl/charge_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module      : charge_accum_bank
//  Description : Charge-deposition grid bank for the PIC scatter stage.
//                Accumulates (address, charge) scatter words into an on-chip
//                grid by pipelined read-modify-write with hazard forwarding,
//                then drains the grid in address order while clearing it.
//  Revision    : 1.0  initial release
// ============================================================================
module charge_accum_bank #(
    parameter int ADDRWIDTH = 10,
    parameter int CWIDTH    = 36,
    parameter int CFRAC     = 24,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDRWIDTH-1:0] in_addr,
    input  logic [CWIDTH-1:0]    in_charge,
    input  logic                 drain_start,
    output logic                 drain_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRWIDTH-1:0] out_addr,
    output logic [CWIDTH-1:0]    out_charge,
    output logic                 overflow,
    input  logic                 clear_ovf
);

    localparam int                   c_DEPTH     = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH-1:0] c_LAST_ADDR = '1;

    // The fraction width only fixes the interpretation of the charge word;
    // it must at least fit inside it.
    if (CFRAC > CWIDTH) begin : g_cfrac_check
        $error("CFRAC must not exceed CWIDTH");
    end

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   cnt_q, cnt_d;          // INIT clear pointer

    // Accumulate pipeline: S1 = read data returning, S2 = sum/commit,
    // WB = copy of the word committed on the previous edge.
    logic                   s1_valid_q;
    logic [ADDRWIDTH-1:0]   s1_addr_q;
    logic [CWIDTH-1:0]      s1_charge_q;
    logic                   s2_valid_q;
    logic [ADDRWIDTH-1:0]   s2_addr_q;
    logic [CWIDTH-1:0]      s2_old_q;
    logic [CWIDTH-1:0]      s2_charge_q;
    logic                   wb_valid_q;
    logic [ADDRWIDTH-1:0]   wb_addr_q;
    logic [CWIDTH-1:0]      wb_data_q;

    logic                   ovf_q, ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic [ADDRWIDTH-1:0]   out_addr_q, out_addr_d;
    logic                   drain_done_q, drain_done_d;

    // Grid memory: one synchronous read port, one write port
    logic [CWIDTH-1:0]      mem [c_DEPTH];
    logic [CWIDTH-1:0]      rdata_q;

    logic                   w_accept;
    logic [CWIDTH:0]        w_sum;
    logic                   w_carry;
    logic [CWIDTH-1:0]      w_s2_wdata;
    logic [CWIDTH-1:0]      w_s1_old;
    logic                   w_drain_hs;
    logic                   w_we;
    logic [ADDRWIDTH-1:0]   w_waddr;
    logic [CWIDTH-1:0]      w_wdata;
    logic [ADDRWIDTH-1:0]   w_raddr;

    assign in_ready   = (state_q == ST_ACC);
    assign w_accept   = in_valid & in_ready;
    assign w_drain_hs = (state_q == ST_DRAIN) & out_valid_q & out_ready;

    // Sum is one bit wider so the carry-out can flag overflow
    assign w_sum      = {1'b0, s2_old_q} + {1'b0, s2_charge_q};
    assign w_carry    = w_sum[CWIDTH];
    assign w_s2_wdata = (w_carry && (SATURATE != 0)) ? {CWIDTH{1'b1}} : w_sum[CWIDTH-1:0];

    // The memory read for the S1 word was taken one edge ago, so it misses
    // the word now in S2 (not yet written) and the word written on that same
    // edge (WB). S2 is younger and therefore has priority.
    assign w_s1_old = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? w_s2_wdata :
                      (wb_valid_q && (wb_addr_q == s1_addr_q)) ? wb_data_q  :
                      rdata_q;

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_charge = out_valid_q ? rdata_q : '0;
    assign drain_done = drain_done_q;
    assign overflow   = ovf_q;

    // Memory port steering: INIT clears, ACC/FLUSH commit sums, DRAIN reads
    // ahead and clears each cell as it is handed off.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = s2_addr_q;
        w_wdata = w_s2_wdata;
        w_raddr = in_addr;
        case (state_q)
            ST_INIT: begin
                w_we    = 1'b1;
                w_waddr = cnt_q;
                w_wdata = '0;
            end
            ST_ACC, ST_FLUSH: begin
                w_we    = s2_valid_q;
            end
            ST_DRAIN: begin
                w_we    = w_drain_hs;
                w_waddr = out_addr_q;
                w_wdata = '0;
                // Re-reading the presented cell while stalled keeps the read
                // register (and so out_charge) stable.
                if (!out_valid_q) begin
                    w_raddr = '0;
                end else if (out_ready) begin
                    w_raddr = out_addr_q + 1'b1;
                end else begin
                    w_raddr = out_addr_q;
                end
            end
            default: begin
                w_we    = 1'b0;
            end
        endcase
    end

    // Grid storage with read-old-data behaviour on a same-edge collision
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
        rdata_q <= mem[w_raddr];
    end

    // Next-state logic for the control FSM and the drain output slot
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        drain_done_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST_ADDR) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (drain_start) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = '0;
                end else if (out_ready) begin
                    if (out_addr_q == c_LAST_ADDR) begin
                        out_valid_d  = 1'b0;
                        drain_done_d = 1'b1;
                        state_d      = ST_ACC;
                    end else begin
                        out_addr_d   = out_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Sticky overflow; a new carry wins over a simultaneous clear
    always_comb begin
        ovf_d = (ovf_q & ~clear_ovf) | (s2_valid_q & w_carry);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            drain_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            drain_done_q <= drain_done_d;
            ovf_q        <= ovf_d;
        end
    end

    // Accumulate pipeline registers; reset discards in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_charge_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            s2_old_q    <= '0;
            s2_charge_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            s1_valid_q  <= w_accept;
            s1_addr_q   <= in_addr;
            s1_charge_q <= in_charge;
            s2_valid_q  <= s1_valid_q;
            s2_addr_q   <= s1_addr_q;
            s2_old_q    <= w_s1_old;
            s2_charge_q <= s1_charge_q;
            wb_valid_q  <= s2_valid_q;
            wb_addr_q   <= s2_addr_q;
            wb_data_q   <= w_s2_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_charge_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_charge_accum_bank
//  Description : Self-checking bench for charge_accum_bank. A saturating and
//                a wrapping instance share all inputs; drained words are
//                checked against a scoreboard of model grid contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_charge_accum_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_addr;
    logic [35:0] in_charge;
    logic        drain_start;
    logic        out_ready;
    logic        clear_ovf;

    logic        s_in_ready, s_drain_done, s_out_valid, s_overflow;
    logic [3:0]  s_out_addr;
    logic [35:0] s_out_charge;
    logic        w_in_ready, w_drain_done, w_out_valid, w_overflow;
    logic [3:0]  w_out_addr;
    logic [35:0] w_out_charge;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        last;
        logic        merge;
        logic        rnd;
        logic [3:0]  addr;
        logic [35:0] charge;
        logic [3:0]  probe;
        logic [35:0] exp_sat;
        logic [35:0] exp_wrap;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [3:0]  a;
        logic [35:0] s;
        logic [35:0] w;
    } exp_t;

    vec_t        vecs [13];
    exp_t        sbq [$];
    logic [35:0] m_sat  [16];
    logic [35:0] m_wrap [16];

    charge_accum_bank #(.ADDRWIDTH(4), .CWIDTH(36), .CFRAC(24), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_addr(in_addr), .in_charge(in_charge),
        .drain_start(drain_start), .drain_done(s_drain_done),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_addr(s_out_addr), .out_charge(s_out_charge),
        .overflow(s_overflow), .clear_ovf(clear_ovf)
    );

    charge_accum_bank #(.ADDRWIDTH(4), .CWIDTH(36), .CFRAC(24), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_addr(in_addr), .in_charge(in_charge),
        .drain_start(drain_start), .drain_done(w_drain_done),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_addr(w_out_addr), .out_charge(w_out_charge),
        .overflow(w_overflow), .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_add(input logic [3:0] a, input logic [35:0] c);
        logic [36:0] s;
        s = {1'b0, m_sat[a]} + {1'b0, c};
        m_sat[a] = s[36] ? 36'hFFFFFFFFF : s[35:0];
        s = {1'b0, m_wrap[a]} + {1'b0, c};
        m_wrap[a] = s[35:0];
    endtask

    task automatic send(input logic [3:0] a, input logic [35:0] c);
        in_valid  = 1'b1;
        in_addr   = a;
        in_charge = c;
        chk("send_in_ready", {63'd0, s_in_ready}, 64'd1);
        model_add(a, c);
        @(posedge clk); #1;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        rst_n = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!s_in_ready && n < 100);
        chk("init_cycles", 64'(n), 64'd16);
        chk("init_wrap_ready", {63'd0, w_in_ready}, 64'd1);
    endtask

    task automatic do_drain(input bit rnd, input bit merge, input logic [3:0] ma,
                            input logic [35:0] mc, input logic [3:0] probe,
                            input logic [35:0] p_sat, input logic [35:0] p_wrap,
                            input int rst_at);
        int          cyc, done_cnt, first_v, done_t;
        bit          stalled, seen_probe;
        logic [3:0]  h_a;
        logic [35:0] h_s, h_w;
        exp_t        e;
        in_valid  = merge;
        in_addr   = ma;
        in_charge = mc;
        if (merge) begin
            chk("merge_in_ready", {63'd0, s_in_ready}, 64'd1);
            model_add(ma, mc);
        end
        for (int a = 0; a < 16; a++) begin
            e.a = 4'(a);
            e.s = m_sat[a];
            e.w = m_wrap[a];
            sbq.push_back(e);
            m_sat[a]  = '0;
            m_wrap[a] = '0;
        end
        drain_start = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk); #1;
        drain_start = 1'b0;
        in_valid    = 1'b0;
        chk("drain_ready_drop", {63'd0, s_in_ready}, 64'd0);
        cyc = 0; done_cnt = 0; first_v = -1; done_t = -1; stalled = 0; seen_probe = 0;
        h_a = '0; h_s = '0; h_w = '0;
        while (cyc < 400 && !(done_cnt > 0 && cyc >= done_t + 3)) begin
            if (s_drain_done) begin
                done_cnt++;
                done_t = cyc;
                chk("done_in_ready", {63'd0, s_in_ready}, 64'd1);
                chk("done_out_valid", {63'd0, s_out_valid}, 64'd0);
                chk("done_sb_empty", 64'(sbq.size()), 64'd0);
            end
            if (s_out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stalled) begin
                    chk("stall_addr", {60'd0, s_out_addr}, {60'd0, h_a});
                    chk("stall_sat", {28'd0, s_out_charge}, {28'd0, h_s});
                    chk("stall_wrap", {28'd0, w_out_charge}, {28'd0, h_w});
                end
                if (rst_at >= 0 && s_out_addr == rst_at[3:0]) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_out_valid_sat", {63'd0, s_out_valid}, 64'd0);
                    chk("rst_out_valid_wrap", {63'd0, w_out_valid}, 64'd0);
                    chk("rst_in_ready", {63'd0, s_in_ready}, 64'd0);
                    chk("rst_out_addr", {60'd0, s_out_addr}, 64'd0);
                    chk("rst_overflow", {63'd0, s_overflow}, 64'd0);
                    sbq.delete();
                    out_ready = 1'b0;
                    return;
                end
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                h_a = s_out_addr; h_s = s_out_charge; h_w = w_out_charge;
                stalled = !out_ready;
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL drain_extra: got word at addr %0d required none", s_out_addr);
                    end else begin
                        e = sbq.pop_front();
                        chk("drain_addr", {60'd0, s_out_addr}, {60'd0, e.a});
                        chk("drain_wrap_addr", {60'd0, w_out_addr}, {60'd0, e.a});
                        chk("drain_sat", {28'd0, s_out_charge}, {28'd0, e.s});
                        chk("drain_wrap", {28'd0, w_out_charge}, {28'd0, e.w});
                        if (e.a == probe) begin
                            seen_probe = 1;
                            chk("probe_sat", {28'd0, s_out_charge}, {28'd0, p_sat});
                            chk("probe_wrap", {28'd0, w_out_charge}, {28'd0, p_wrap});
                        end
                    end
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                stalled   = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_done_count", 64'(done_cnt), 64'd1);
        chk("probe_seen", {63'd0, seen_probe}, 64'd1);
        if (!rnd) chk("drain_throughput", 64'(done_t - first_v), 64'd16);
    endtask

    initial begin
        // last merge rnd addr charge probe exp_sat exp_wrap exp_ovf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd3,  36'h001000000, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd3,  36'h001000000, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd3,  36'h001000000, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd3,  36'h001000000, 4'd3,  36'h004000000, 36'h004000000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd5,  36'h000800000, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd5,  36'h000800000, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd6,  36'h000800000, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd5,  36'h000800000, 4'd5,  36'h001800000, 36'h001800000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0,  36'hFFFFFFFF0, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd0,  36'h000000020, 4'd0,  36'hFFFFFFFFF, 36'h000000010, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd15, 36'h7FFFFFFFF, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd14, 36'h000000001, 4'd0,  36'h0,         36'h0,         1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd15, 36'h7FFFFFFFF, 4'd15, 36'hFFFFFFFFE, 36'hFFFFFFFFE, 1'b0};
        for (int a = 0; a < 16; a++) begin
            m_sat[a]  = '0;
            m_wrap[a] = '0;
        end

        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_charge = '0;
        drain_start = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'd0, s_in_ready}, 64'd0);
        chk("reset_out_valid", {63'd0, s_out_valid}, 64'd0);
        chk("reset_drain_done", {63'd0, s_drain_done}, 64'd0);
        chk("reset_overflow", {63'd0, s_overflow}, 64'd0);
        chk("reset_out_addr", {60'd0, s_out_addr}, 64'd0);
        chk("reset_out_charge", {28'd0, s_out_charge}, 64'd0);
        chk("reset_wrap_out_valid", {63'd0, w_out_valid}, 64'd0);
        wait_init();

        // Freshly initialised grid drains as all zeros
        do_drain(1'b0, 1'b0, 4'd0, 36'd0, 4'd0, 36'd0, 36'd0, -1);

        // Table-driven accumulation groups, each followed by a drain
        for (int i = 0; i < 13; i++) begin
            if (!vecs[i].merge) send(vecs[i].addr, vecs[i].charge);
            if (vecs[i].last) begin
                do_drain(vecs[i].rnd, vecs[i].merge, vecs[i].addr, vecs[i].charge,
                         vecs[i].probe, vecs[i].exp_sat, vecs[i].exp_wrap, -1);
                chk("group_ovf_sat", {63'd0, s_overflow}, {63'd0, vecs[i].exp_ovf});
                chk("group_ovf_wrap", {63'd0, w_overflow}, {63'd0, vecs[i].exp_ovf});
                clear_ovf = 1'b1;
                @(posedge clk); #1;
                clear_ovf = 1'b0;
                chk("clear_ovf_sat", {63'd0, s_overflow}, 64'd0);
                chk("clear_ovf_wrap", {63'd0, w_overflow}, 64'd0);
            end
        end

        // A second drain right after a drain sees a cleared grid
        do_drain(1'b1, 1'b0, 4'd0, 36'd0, 4'd7, 36'd0, 36'd0, -1);

        // Carry arriving while clear_ovf is held: set wins and stays sticky
        clear_ovf = 1'b1;
        send(4'd1, 36'hFFFFFFFFF);
        send(4'd1, 36'h000000001);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("setwin_before", {63'd0, s_overflow}, 64'd0);
        @(posedge clk); #1;
        clear_ovf = 1'b0;
        chk("setwin_sat", {63'd0, s_overflow}, 64'd1);
        chk("setwin_wrap", {63'd0, w_overflow}, 64'd1);
        @(posedge clk); #1;
        chk("setwin_sticky", {63'd0, s_overflow}, 64'd1);

        // Load some cells, then reset in the middle of the drain at addr 7
        send(4'd7,  36'h000000123);
        send(4'd8,  36'h000000005);
        send(4'd9,  36'h000000ABC);
        send(4'd10, 36'h000000001);
        in_valid = 1'b0;
        do_drain(1'b0, 1'b0, 4'd0, 36'd0, 4'd1, 36'hFFFFFFFFF, 36'h000000000, 7);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_in_ready", {63'd0, s_in_ready}, 64'd0);
        for (int a = 0; a < 16; a++) begin
            m_sat[a]  = '0;
            m_wrap[a] = '0;
        end
        wait_init();
        do_drain(1'b0, 1'b0, 4'd0, 36'd0, 4'd7, 36'd0, 36'd0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/charge_accum_bank.md
Name: charge_accum_bank

Overview:
- Parametrised charge-deposition bank for the PIC scatter stage.
- Accepts a stream of (grid address, charge) scatter words, accumulates each into an on-chip grid memory by read-modify-write with full hazard forwarding, one word per cycle.
- On command, drains the whole grid in address order and clears it behind the drain.
- One instance per grid bank (four banks cover the 64x64 grid); generalises the fixed-width scatter word to configurable depth, charge width and overflow mode.

Parameters:
ADDRWIDTH  10  bank address width; DEPTH = 2**ADDRWIDTH cells
CWIDTH  36  unsigned charge width (fixed point, CFRAC fraction bits)
CFRAC  24  charge fraction bits; informational only, no arithmetic dependence
SATURATE  1  1 = saturate sums at all-ones; 0 = wrap modulo 2**CWIDTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  scatter word valid
in_ready  out  1  block accepts scatter word this cycle
in_addr  in  ADDRWIDTH  cell address
in_charge  in  CWIDTH  charge to add
drain_start  in  1  request drain; sampled only in ACC state
drain_done  out  1  one-cycle pulse after last drained word handshakes
out_valid  out  1  drained word valid
out_ready  in  1  consumer accepts drained word
out_addr  out  ADDRWIDTH  address of drained word
out_charge  out  CWIDTH  accumulated charge of drained word
overflow  out  1  sticky; set on any sum carry-out
clear_ovf  in  1  synchronous clear of overflow (set wins if same cycle)

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: in_ready=0, out_valid=0, drain_done=0, overflow=0, out_addr=0, out_charge=0, pipeline valids=0, state=INIT, address counter=0.
- Memory: DEPTH x CWIDTH, synchronous read with 1-cycle latency, one read port and one write port. Contents are not reset.
- State machine: INIT -> ACC -> FLUSH -> DRAIN -> ACC.
- INIT:
  - writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), in_ready=0.
  - Then goes to ACC; in_ready=1 on the following cycle.
  - Reset asserted mid-operation from any state re-enters INIT; in-flight words are discarded.
- ACC: in_ready=1; a word is accepted when in_valid & in_ready.
  - S0: issues read of in_addr.
  - S1: read data returns.
  - S2: sum = old + charge, computed CWIDTH+1 wide; written to memory at the end of S2.
  - Accept-to-commit latency: 3 cycles. A drain read issued after that sees the value.
  - Throughput is 1 word/cycle for any address sequence, including repeats.
- Hazard forwarding:
  - If the S1 or S2 address equals the address being read, old value := the youngest in-flight sum for that address instead of the memory data.
  - Back-to-back identical addresses produce exact cumulative sums.
- Overflow:
  - If sum bit CWIDTH = 1, overflow is set.
  - SATURATE=1 writes all-ones; SATURATE=0 writes sum[CWIDTH-1:0].
- drain_start while in ACC:
  - in_ready drops on the next cycle; a word handshaking in the same cycle as drain_start is accepted.
  - Goes to FLUSH.
  - drain_start outside ACC is ignored.
- FLUSH: waits until S0..S2 are empty (at most 3 cycles), then goes to DRAIN.
- DRAIN:
  - Reads addresses 0..DEPTH-1 in order.
  - out_valid asserts with out_addr/out_charge stable until out_ready.
  - On each handshake, writes 0 to that address.
  - Prefetch is allowed, but words must appear in order without gaps or duplicates under any out_ready pattern.
  - With out_ready held at 1, throughput is 1 word/cycle after a first-word latency of at most 2 cycles from DRAIN entry.
- After the handshake of address DEPTH-1:
  - drain_done pulses for 1 cycle and out_valid is 0.
  - Goes to ACC; in_ready=1 on the same cycle as drain_done.
- clear_ovf is honoured in all states.

Test Plan:
- Reset release, ADDRWIDTH=4 -> in_ready stays 0 for 16 cycles, then 1; an immediate drain returns 16 words, all charge 0.
- Accept 0x001000000 (1.0) to addr 3 on 4 consecutive cycles, then drain -> addr 3 reads 0x004000000, all others 0, overflow=0.
- Alternate addr 5,5,6,5 with charge 0x000800000 back-to-back -> drain shows addr5=0x001800000, addr6=0x000800000 (forwarding from S1 and S2).
- SATURATE=1: addr 0 gets 0xFFFFFFFF0 then 0x000000020 -> addr0=0xFFFFFFFFF, overflow=1; SATURATE=0 variant -> addr0=0x000000010, overflow=1. Then clear_ovf pulse -> overflow=0.
- Drain with out_ready toggling on a random 50% pattern -> addresses 0..15 appear exactly once in order, data stable while stalled; a second drain returns all zeros; drain_done pulses exactly once per drain.
- Assert rst_n low mid-DRAIN (at addr 7) -> out_valid=0 immediately; INIT reruns for 16 cycles; the next drain reads all zeros.
